// File: rtl/dtc_sched_pkg.sv
// Shared types and defaults for the decision-tree classifier request schedulers.
package dtc_sched_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StEval = 2'd1,
    StResp = 2'd2
  } sched_state_e;

  localparam int unsigned FeatWDefault = 8;
  localparam int unsigned ClsWDefault  = 63;
  // Settle window is 0..15 cycles.
  localparam int unsigned SettleCntW   = 4;

  // Width of a requester index; never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dtc_rr_arb.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module dtc_rr_arb
  import dtc_sched_pkg::*;
#(
  parameter int unsigned N   = 4,
  parameter int unsigned IdW = id_width(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IdW-1:0] ptr,
  output logic [N-1:0]   gnt,
  output logic [IdW-1:0] gnt_idx,
  output logic           any
);

  // Scan N positions starting at ptr; the first requester found wins.
  always_comb begin
    int unsigned k;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    k       = 0;
    for (int unsigned i = 0; i < N; i++) begin
      k = (32'(ptr) + i) % N;
      if (!any && req[k]) begin
        any     = 1'b1;
        gnt[k]  = 1'b1;
        gnt_idx = IdW'(k);
      end
    end
  end

endmodule

// File: rtl/dtc_req_scheduler.sv
// Time-shares one combinational classifier between NREQ requesters.
// Round-robin grant, hold the feature for SETTLE+1 cycles, capture and return the class vector.
module dtc_req_scheduler
  import dtc_sched_pkg::*;
#(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned FEAT_W = FeatWDefault,
  parameter int unsigned CLS_W  = ClsWDefault,
  parameter int unsigned SETTLE = 0,
  parameter int unsigned CNT_W  = 16,
  localparam int unsigned IdW   = id_width(NREQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*FEAT_W-1:0]   req_feat,
  output logic [FEAT_W-1:0]        cls_inp,
  input  logic [CLS_W-1:0]         cls_outp,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IdW-1:0]           rsp_id,
  output logic [CLS_W-1:0]         rsp_class,
  output logic                     busy,
  output logic [CNT_W-1:0]         done_cnt
);

  sched_state_e            state_q, state_d;
  logic [IdW-1:0]          ptr_q;
  logic [FEAT_W-1:0]       feat_q;
  logic [IdW-1:0]          id_q;
  logic [SettleCntW-1:0]   settle_q;
  logic                    rsp_valid_q;
  logic [IdW-1:0]          rsp_id_q;
  logic [CLS_W-1:0]        rsp_class_q;
  logic [CNT_W-1:0]        done_cnt_q;

  logic [NREQ-1:0]         gnt;
  logic [IdW-1:0]          gnt_idx;
  logic                    gnt_any;
  logic [FEAT_W-1:0]       feat_sel;
  logic [IdW-1:0]          ptr_next;

  dtc_rr_arb #(
    .N   (NREQ),
    .IdW (IdW)
  ) u_arb (
    .req     (req_valid),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (gnt_any)
  );

  assign feat_sel = req_feat[32'(gnt_idx) * FEAT_W +: FEAT_W];
  assign ptr_next = (gnt_idx == IdW'(NREQ - 1)) ? '0 : gnt_idx + IdW'(1);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: grant -> evaluate for SETTLE+1 cycles -> hold response until accepted.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (gnt_any) state_d = StEval;
      StEval:  if (settle_q == '0) state_d = StResp;
      StResp:  if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs: grants only in idle; classifier input held from grant until back in idle.
  always_comb begin
    req_ready = '0;
    busy      = 1'b1;
    cls_inp   = feat_q;
    if (state_q == StIdle) begin
      req_ready = gnt;
      busy      = 1'b0;
      cls_inp   = '0;
    end
  end

  // Datapath: latch the granted request, count down the settle window, capture and retire.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= '0;
      feat_q      <= '0;
      id_q        <= '0;
      settle_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_class_q <= '0;
      done_cnt_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (gnt_any) begin
            feat_q   <= feat_sel;
            id_q     <= gnt_idx;
            settle_q <= SettleCntW'(SETTLE);
            ptr_q    <= ptr_next;
          end
        end
        StEval: begin
          if (settle_q != '0) begin
            settle_q <= settle_q - SettleCntW'(1);
          end else begin
            rsp_class_q <= cls_outp;
            rsp_id_q    <= id_q;
            rsp_valid_q <= 1'b1;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            done_cnt_q  <= done_cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_class = rsp_class_q;
  assign done_cnt  = done_cnt_q;

endmodule
